// File: rtl/bp_lce_msg_arbiter_pkg.sv
// Shared types and helpers for the LCE-to-CCE message arbiter.
// Imported by the interface, the grant selector and the top.
package bp_lce_msg_arbiter_pkg;

    typedef enum logic [0:0] {
        e_arb_rr    = 1'b0,
        e_arb_fixed = 1'b1
    } bp_arb_mode_e;

    // Starvation limits are at most 255, so 8 bits covers every legal counter value.
    localparam int cnt_width_gp = 8;

    function automatic int id_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [cnt_width_gp-1:0] sat_inc_f(
        input logic [cnt_width_gp-1:0] cnt,
        input logic [cnt_width_gp-1:0] limit
    );
        return (cnt >= limit) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/bp_lce_msg_arbiter_if.sv
// Handshake bundle between the LCE sub-units (packed sources) and the arbitrated network side.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface bp_lce_msg_arbiter_if
    import bp_lce_msg_arbiter_pkg::*;
#(
    parameter int num_src_p   = 2,
    parameter int msg_width_p = 64
);
    localparam int id_width_lp = id_width_f(num_src_p);

    logic [num_src_p*msg_width_p-1:0] msg_i;
    logic [num_src_p-1:0]             v_i;
    logic [num_src_p-1:0]             ready_o;
    logic [msg_width_p-1:0]           msg_o;
    logic                             v_o;
    logic                             ready_i;
    logic [id_width_lp-1:0]           grant_id_o;

    modport slave (
        input  msg_i, v_i, ready_i,
        output ready_o, msg_o, v_o, grant_id_o
    );

    modport master (
        output msg_i, v_i, ready_i,
        input  ready_o, msg_o, v_o, grant_id_o
    );

endinterface

// File: rtl/bp_lce_msg_arb_sel.sv
// Purely combinational grant selection: round-robin after ptr, or lowest index with
// starved sources taking precedence in fixed mode.
module bp_lce_msg_arb_sel
    import bp_lce_msg_arbiter_pkg::*;
#(
    parameter int num_src_p = 2,
    parameter int id_width_lp = id_width_f(num_src_p)
) (
    input  logic [num_src_p-1:0]   nonempty_i,
    input  logic [id_width_lp-1:0] ptr_i,
    input  logic [num_src_p-1:0]   starved_i,
    input  bp_arb_mode_e           mode_i,
    output logic [num_src_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic                   v_o
);
    logic [num_src_p-1:0] cand_s;
    logic [num_src_p-1:0] starved_pend_s;
    int                   start_s;

    // Candidate set and search origin, then a reverse scan so the first candidate in search order wins.
    always_comb begin
        starved_pend_s = starved_i & nonempty_i;
        case (mode_i)
            e_arb_fixed: begin
                cand_s  = (|starved_pend_s) ? starved_pend_s : nonempty_i;
                start_s = 0;
            end
            e_arb_rr: begin
                cand_s  = nonempty_i;
                start_s = (int'(ptr_i) + 1) % num_src_p;
            end
            default: begin
                cand_s  = nonempty_i;
                start_s = (int'(ptr_i) + 1) % num_src_p;
            end
        endcase

        grant_id_o = '0;
        for (int i = num_src_p - 1; i >= 0; i--) begin
            int idx;
            idx        = (start_s + i) % num_src_p;
            grant_id_o = cand_s[idx] ? id_width_lp'(idx) : grant_id_o;
        end

        v_o     = |cand_s;
        grant_o = v_o ? ({{(num_src_p-1){1'b0}}, 1'b1} << grant_id_o) : '0;
    end

endmodule

// File: rtl/bp_lce_msg_arbiter_chk.sv
// Simulation-only protocol and parameter checks for the LCE message arbiter.
module bp_lce_msg_arbiter_chk #(
    parameter int num_src_p = 2,
    parameter int els_p     = 2
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    input logic [num_src_p-1:0] v_i,
    input logic [num_src_p-1:0] ready_o
);
    a_params: assert property (@(posedge clk_i)
        (num_src_p >= 2) && ((els_p & (els_p - 1)) == 0));

    for (genvar k = 0; k < num_src_p; k++) begin : g_hold
        a_v_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
            (v_i[k] && !ready_o[k]) |=> v_i[k]);
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with a combinational head; full/empty come from
// wrap-bit pointers so every one of the els_p slots is usable.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p-1:0] mem_r [els_p];
    logic [lg_els_lp:0] wptr_r;
    logic [lg_els_lp:0] rptr_r;
    logic               enq_s;
    logic               deq_s;

    assign ready_o = ~((wptr_r[lg_els_lp] != rptr_r[lg_els_lp])
                       && (wptr_r[lg_els_lp-1:0] == rptr_r[lg_els_lp-1:0]));
    assign v_o     = (wptr_r != rptr_r);
    assign enq_s   = v_i & ready_o;
    assign deq_s   = yumi_i & v_o;
    assign data_o  = mem_r[rptr_r[lg_els_lp-1:0]];

    // Storage write; contents need no reset because v_o gates every read.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[wptr_r[lg_els_lp-1:0]] <= data_i;
        end
    end

    // Read and write pointers, including the wrap bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (enq_s) begin
                wptr_r <= wptr_r + {{lg_els_lp{1'b0}}, 1'b1};
            end
            if (deq_s) begin
                rptr_r <= rptr_r + {{lg_els_lp{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/bp_lce_msg_arbiter.sv
// N-source arbiter for LCE-to-CCE message channels: per-source FIFOs, round-robin or
// starvation-guarded fixed priority, and a single registered ready/valid output stage.
module bp_lce_msg_arbiter
    import bp_lce_msg_arbiter_pkg::*;
#(
    parameter int num_src_p      = 2,
    parameter int msg_width_p    = 64,
    parameter int els_p          = 2,
    parameter int starve_limit_p = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                mode_i,
    bp_lce_msg_arbiter_if.slave link
);
    localparam int id_width_lp = id_width_f(num_src_p);
    localparam logic [cnt_width_gp-1:0] starve_limit_lp = cnt_width_gp'(starve_limit_p);

    logic [num_src_p-1:0]    fifo_ready_s;
    logic [num_src_p-1:0]    nonempty_s;
    logic [num_src_p-1:0]    enq_s;
    logic [num_src_p-1:0]    deq_s;
    logic [num_src_p-1:0]    starved_s;
    logic [num_src_p-1:0]    grant_s;
    logic [msg_width_p-1:0]  head_s [num_src_p];
    logic [id_width_lp-1:0]  grant_id_s;
    logic                    any_s;
    logic                    load_en_s;
    bp_arb_mode_e            mode_s;

    logic                    ready_en_r;
    logic                    v_r;
    logic [msg_width_p-1:0]  msg_r;
    logic [id_width_lp-1:0]  grant_id_r;
    logic [id_width_lp-1:0]  ptr_r;
    logic [cnt_width_gp-1:0] cnt_r [num_src_p];

    assign mode_s    = bp_arb_mode_e'(mode_i);
    assign load_en_s = ~v_r | link.ready_i;
    assign enq_s     = link.v_i & link.ready_o;
    assign deq_s     = grant_s & {num_src_p{load_en_s}};

    for (genvar k = 0; k < num_src_p; k++) begin : g_src
        bsg_fifo_1r1w_small #(
            .width_p(msg_width_p),
            .els_p  (els_p)
        ) fifo (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .v_i      (enq_s[k]),
            .data_i   (link.msg_i[k*msg_width_p +: msg_width_p]),
            .ready_o  (fifo_ready_s[k]),
            .v_o      (nonempty_s[k]),
            .data_o   (head_s[k]),
            .yumi_i   (deq_s[k])
        );

        assign starved_s[k] = (cnt_r[k] == starve_limit_lp);
    end

    bp_lce_msg_arb_sel #(
        .num_src_p(num_src_p)
    ) sel (
        .nonempty_i(nonempty_s),
        .ptr_i     (ptr_r),
        .starved_i (starved_s),
        .mode_i    (mode_s),
        .grant_o   (grant_s),
        .grant_id_o(grant_id_s),
        .v_o       (any_s)
    );

    // Holds ready_o low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Output stage and last-granted pointer; the pointer follows every grant in either mode.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r        <= 1'b0;
            msg_r      <= '0;
            grant_id_r <= '0;
            ptr_r      <= id_width_lp'(num_src_p - 1);
        end else if (load_en_s) begin
            if (any_s) begin
                v_r        <= 1'b1;
                msg_r      <= head_s[grant_id_s];
                grant_id_r <= grant_id_s;
                ptr_r      <= grant_id_s;
            end else begin
                v_r        <= 1'b0;
            end
        end
    end

    // Starvation counters only move in fixed mode; round-robin freezes them in place.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < num_src_p; k++) begin
                cnt_r[k] <= '0;
            end
        end else if (mode_s == e_arb_fixed) begin
            for (int k = 0; k < num_src_p; k++) begin
                if (!nonempty_s[k] || (load_en_s && grant_s[k])) begin
                    cnt_r[k] <= '0;
                end else if (load_en_s) begin
                    cnt_r[k] <= sat_inc_f(cnt_r[k], starve_limit_lp);
                end
            end
        end
    end

    assign link.ready_o    = fifo_ready_s & {num_src_p{ready_en_r}};
    assign link.v_o        = v_r;
    assign link.msg_o      = msg_r;
    assign link.grant_id_o = grant_id_r;

    bp_lce_msg_arbiter_chk #(
        .num_src_p(num_src_p),
        .els_p    (els_p)
    ) chk (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (link.v_i),
        .ready_o  (link.ready_o)
    );

endmodule

// File: tb/tb_bp_lce_msg_arbiter.sv
// Directed bench for bp_lce_msg_arbiter: 4 sources, 16-bit messages, depth-2 FIFOs, limit 8.
module tb_bp_lce_msg_arbiter;
    import bp_lce_msg_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic mode;

    always #5 clk = ~clk;

    bp_lce_msg_arbiter_if #(.num_src_p(N), .msg_width_p(W)) link ();

    bp_lce_msg_arbiter #(
        .num_src_p     (N),
        .msg_width_p   (W),
        .els_p         (2),
        .starve_limit_p(8)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .mode_i   (mode),
        .link     (link)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [W-1:0] src_q [N][$];
    logic [W-1:0] exp_q [N][$];
    logic [W-1:0] msg_log [$];
    logic [N-1:0] cont;
    int           seq [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (cont[k] && src_q[k].size() == 0) begin
                src_q[k].push_back(W'(k * 256 + (seq[k] % 256)));
                seq[k]++;
            end
            link.v_i[k] = (src_q[k].size() != 0);
            link.msg_i[k*W +: W] = (src_q[k].size() != 0) ? src_q[k][0] : '0;
        end
    endtask

    // One clock: record accepts/transfers seen before the edge, score transfers, re-drive.
    task automatic cycle();
        logic [N-1:0] acc;
        logic         xfer;
        logic [W-1:0] msg_pre;
        logic [W-1:0] expv;
        int           id_pre;
        acc     = link.v_i & link.ready_o;
        xfer    = link.v_o & link.ready_i;
        msg_pre = link.msg_o;
        id_pre  = int'(link.grant_id_o);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) exp_q[k].push_back(src_q[k].pop_front());
        end
        if (xfer) begin
            if (exp_q[id_pre].size() != 0) expv = exp_q[id_pre].pop_front();
            else expv = 16'hDEAD;
            check_eq("sb_data", 32'(msg_pre), 32'(expv));
            msg_log.push_back(msg_pre);
        end
        drive();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        cont = '0;
        drive();
        #1;
        check_eq("rst_v_o", 32'(link.v_o), 32'd0);
        check_eq("rst_msg_o", 32'(link.msg_o), 32'd0);
        check_eq("rst_grant_id", 32'(link.grant_id_o), 32'd0);
        check_eq("rst_ready_o", 32'(link.ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ready_after", 32'(link.ready_o), 32'hF);
        msg_log.delete();
    endtask

    task automatic drain();
        int  n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 60) begin
            busy = link.v_o;
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() != 0 || exp_q[k].size() != 0) busy = 1'b1;
            end
            if (busy) begin
                cycle();
                n++;
            end
        end
        check_eq("drain_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] t3_exp [4];
        int           t5_rr [4];
        int           eg;
        t3_exp = '{16'h0301, 16'h0321, 16'h0302, 16'h0303};
        t5_rr  = '{2, 0, 2, 0};
        rst_n = 1'b1;
        mode  = 1'b0;
        link.ready_i = 1'b1;
        link.v_i     = '0;
        link.msg_i   = '0;
        cont = '0;
        for (int k = 0; k < N; k++) seq[k] = 0;

        // Reset then a single message from source 1.
        do_reset();
        src_q[1].push_back(16'h00A5);
        drive();
        cycle();
        check_eq("t1_v_before", 32'(link.v_o), 32'd0);
        cycle();
        check_eq("t1_v", 32'(link.v_o), 32'd1);
        check_eq("t1_msg", 32'(link.msg_o), 32'h00A5);
        check_eq("t1_id", 32'(link.grant_id_o), 32'd1);
        cycle();
        check_eq("t1_v_after", 32'(link.v_o), 32'd0);

        // Round-robin fairness with all sources busy.
        do_reset();
        cont = 4'b1111;
        drive();
        cycle();
        cycle();
        for (int i = 0; i < 12; i++) begin
            check_eq("t2_v", 32'(link.v_o), 32'd1);
            check_eq("t2_rr_id", 32'(link.grant_id_o), 32'(i % 4));
            cycle();
        end
        cont = '0;
        drain();

        // Backpressure with three queued messages on source 0 and one on source 2.
        do_reset();
        link.ready_i = 1'b0;
        src_q[0].push_back(16'h0301);
        src_q[0].push_back(16'h0302);
        src_q[0].push_back(16'h0303);
        src_q[2].push_back(16'h0321);
        drive();
        cycle();
        cycle();
        check_eq("t3_msg_load", 32'(link.msg_o), 32'h0301);
        check_eq("t3_id_load", 32'(link.grant_id_o), 32'd0);
        cycle();
        check_eq("t3_ready_full", 32'(link.ready_o), 32'hE);
        for (int s = 0; s < 3; s++) begin
            cycle();
            check_eq("t3_v_hold", 32'(link.v_o), 32'd1);
            check_eq("t3_msg_hold", 32'(link.msg_o), 32'h0301);
            check_eq("t3_id_hold", 32'(link.grant_id_o), 32'd0);
        end
        link.ready_i = 1'b1;
        drain();
        check_eq("t3_count", 32'(msg_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < msg_log.size()) check_eq("t3_order", 32'(msg_log[i]), 32'(t3_exp[i]));
        end

        // Fixed priority with starvation guard: source 1 every 9th grant.
        do_reset();
        mode = 1'b1;
        cont = 4'b0011;
        drive();
        cycle();
        for (int g = 0; g < 27; g++) begin
            cycle();
            eg = ((g % 9) == 8) ? 1 : 0;
            check_eq("t4_v", 32'(link.v_o), 32'd1);
            check_eq("t4_id", 32'(link.grant_id_o), 32'(eg));
            check_eq("t4_cnt1", 32'(dut.cnt_r[1]), (eg == 1) ? 32'd0 : 32'((g % 9) + 1));
        end
        cont = '0;
        drain();

        // Mode switch with source 2's counter at 5.
        do_reset();
        mode = 1'b1;
        cont = 4'b0101;
        drive();
        repeat (6) cycle();
        check_eq("t5_fixed_id", 32'(link.grant_id_o), 32'd0);
        check_eq("t5_cnt_at5", 32'(dut.cnt_r[2]), 32'd5);
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t5_rr_id", 32'(link.grant_id_o), 32'(t5_rr[i]));
            check_eq("t5_cnt_frozen", 32'(dut.cnt_r[2]), 32'd5);
        end
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t5_fx_id", 32'(link.grant_id_o), (i < 3) ? 32'd0 : 32'd2);
            check_eq("t5_cnt_run", 32'(dut.cnt_r[2]), (i < 3) ? 32'(6 + i) : 32'd0);
        end
        cont = '0;
        drain();
        mode = 1'b0;

        // Reset in the middle of a stalled burst.
        do_reset();
        link.ready_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 3; j++) src_q[k].push_back(W'(16'h0600 + k * 16 + j));
        end
        drive();
        repeat (3) cycle();
        check_eq("t6_pre_v", 32'(link.v_o), 32'd1);
        check_eq("t6_pre_ready", 32'(link.ready_o), 32'd0);
        do_reset();
        link.ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("t6_no_stale", 32'(link.v_o), 32'd0);
        end
        src_q[3].push_back(16'h06B3);
        drive();
        cycle();
        cycle();
        check_eq("t6_fresh_v", 32'(link.v_o), 32'd1);
        check_eq("t6_fresh_id", 32'(link.grant_id_o), 32'd3);
        check_eq("t6_fresh_msg", 32'(link.msg_o), 32'h06B3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
